// File: rtl/four_bit_run_counter.sv
// Run counter: loads start_val, increments through a half-adder chain up to stop_val, then holds in DONE until ack.
// Optional WRAP_COUNT_EN adds wrap_cnt, a saturating count of 15->0 wraps within the current run.
//
// state | meaning
// IDLE  | waiting for start; count holds its last value
// RUN   | counting toward stop_val; pause freezes count and state
// DONE  | count == stop_val; waits for ack (or one cycle with AUTO_ACK)
module four_bit_run_counter #(
  parameter bit AUTO_ACK = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] start_val,
  input  logic [3:0] stop_val,
  input  logic       pause,
  input  logic       ack,
  output logic [3:0] count,
  output logic       busy,
  output logic       done,
  output logic       wrap
`ifdef WRAP_COUNT_EN
  ,
  output logic [3:0] wrap_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] count_nxt;
  logic       wrap_nxt;

  // Incrementer: half-adder chain with carry-in tied to 1
  logic [3:0] inc_sum;
  logic       c1, c2, c3, inc_carry;

  assign inc_sum[0] = ~count[0];
  assign c1         = count[0];
  assign inc_sum[1] = count[1] ^ c1;
  assign c2         = count[1] & c1;
  assign inc_sum[2] = count[2] ^ c2;
  assign c3         = count[2] & c2;
  assign inc_sum[3] = count[3] ^ c3;
  assign inc_carry  = count[3] & c3;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    wrap_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          count_nxt = start_val;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!pause) begin
          if (count == stop_val) begin
            state_nxt = DONE;
          end else begin
            count_nxt = inc_sum;
            wrap_nxt  = inc_carry;
          end
        end
      end
      DONE: begin
        if (ack || AUTO_ACK) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= 4'd0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

`ifdef WRAP_COUNT_EN
  // wrap_nxt is high exactly on an advancing 15->0 step
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_cnt <= 4'd0;
    end else if (state == IDLE && start) begin
      wrap_cnt <= 4'd0;
    end else if (wrap_nxt && wrap_cnt != 4'd15) begin
      wrap_cnt <= wrap_cnt + 4'd1;
    end
  end
`endif

endmodule
